stacktr_reader: RTL and testbench

Debug-side reader for the stack trace buffer. On a request from the debug port it walks the buffer from the newest call record to the oldest and streams each record out over a valid/ready channel. It drives the buffer's read-address port and consumes its registered read data. It never writes the buffer.

---
 rtl/stacktr_reader_pkg.sv | 37 +++
 rtl/stacktr_reader.sv | 108 ++++++++++
 tb/tb_stacktr_reader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stacktr_reader_pkg.sv
// Shared types and constants for the stack trace buffer reader.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package stacktr_reader_pkg;

  localparam int CFG_LOG2_STACK_TRACE_ADDR = 5;
  localparam int RISCV_ARCH                = 64;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    HOLD,
    DONE
  } stacktr_state_e;

  // Register widths follow the package address width; the reader's abits
  // parameter is expected to match it.
  typedef struct packed {
    stacktr_state_e                         state;
    logic [CFG_LOG2_STACK_TRACE_ADDR-1:0]   addr;
    logic [CFG_LOG2_STACK_TRACE_ADDR:0]     cnt;
    logic [CFG_LOG2_STACK_TRACE_ADDR:0]     index;
    logic [2*RISCV_ARCH-1:0]                data;
    logic                                   last;
  } stacktr_reader_registers;

  localparam stacktr_reader_registers stacktr_reader_r_reset = '{
    state: IDLE,
    addr:  '0,
    cnt:   '0,
    index: '0,
    data:  '0,
    last:  1'b0
  };

endpackage

// File: rtl/stacktr_reader.sv
// Walks the stack trace buffer newest-to-oldest and streams records out (macro STACKTR_READER_WRAP_EN selects circular addressing).
// Latency: first beat valid 3 cycles after i_start; 3 cycles per beat with i_ready held high.
// Backpressure: a beat is held stable in HOLD until i_ready; no further reads are issued while stalled.
module stacktr_reader
  import stacktr_reader_pkg::*;
#(
  parameter int abits = CFG_LOG2_STACK_TRACE_ADDR
) (
  input  logic                    i_clk,
  input  logic                    i_nrst,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [abits:0]          i_depth,
  input  logic [abits-1:0]        i_wptr,
  output logic [abits-1:0]        o_raddr,
  input  logic [2*RISCV_ARCH-1:0] i_rdata,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [2*RISCV_ARCH-1:0] o_data,
  output logic [abits-1:0]        o_index,
  output logic                    o_last,
  output logic                    o_busy,
  output logic                    o_done
);

  // Number of buffer entries, expressed at counter width so cnt=SIZE fits.
  localparam logic [abits:0] SIZE = {1'b1, {abits{1'b0}}};

  stacktr_reader_registers r;
  stacktr_reader_registers rin;

  logic [abits:0] depth_sat;

`ifndef STACKTR_READER_WRAP_EN
  // Linear stack: the write pointer carries no information for the walk.
  logic unused_wptr;
  assign unused_wptr = ^i_wptr;
`endif

  // The writer saturates depth, but clamp anyway so a bad value cannot over-walk.
  assign depth_sat = (i_depth > SIZE) ? SIZE : i_depth;

  // Next-state and datapath updates; abort overrides everything else.
  always_comb begin
    rin = r;
    case (r.state)
      IDLE: begin
        if (i_start && !i_abort) begin
          rin.cnt   = depth_sat;
          rin.index = '0;
`ifdef STACKTR_READER_WRAP_EN
          rin.addr  = i_wptr - 1'b1;
`else
          rin.addr  = depth_sat[abits-1:0] - 1'b1;
`endif
          rin.state = (depth_sat == '0) ? DONE : ADDR;
        end
      end
      ADDR: begin
        rin.state = DATA;
      end
      DATA: begin
        rin.data  = i_rdata;
        rin.last  = (r.index == (r.cnt - 1'b1));
        rin.state = HOLD;
      end
      HOLD: begin
        if (i_ready) begin
          if (r.last) begin
            rin.state = DONE;
          end else begin
            rin.addr  = r.addr - 1'b1;
            rin.index = r.index + 1'b1;
            rin.state = ADDR;
          end
        end
      end
      DONE: begin
        rin.state = IDLE;
      end
      default: begin
        rin.state = IDLE;
      end
    endcase

    if (i_abort && (r.state != IDLE)) begin
      rin.state = IDLE;
    end
  end

  // Register bank with asynchronous clear so a mid-dump reset drops outputs at once.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r <= stacktr_reader_r_reset;
    end else begin
      r <= rin;
    end
  end

  assign o_raddr = r.addr;
  assign o_valid = (r.state == HOLD);
  assign o_data  = r.data;
  assign o_index = r.index[abits-1:0];
  assign o_last  = r.last && (r.state == HOLD);
  assign o_busy  = (r.state != IDLE);
  assign o_done  = (r.state == DONE);

endmodule

// File: tb/tb_stacktr_reader.sv
// Bench for stacktr_reader: registered-read RAM model, beat scoreboard, directed dumps.
// Latency: checks 3-cycle first beat, 1-cycle empty-dump done, done/busy timing.
// Backpressure: stalls the consumer and checks the held beat stays stable.
module tb_stacktr_reader;

  localparam int AB = 5;
  localparam int DW = 128;

  logic          i_clk = 1'b0;
  logic          i_nrst = 1'b0;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic [AB:0]   i_depth = '0;
  logic [AB-1:0] i_wptr = '0;
  logic [AB-1:0] o_raddr;
  logic [DW-1:0] i_rdata = '0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [DW-1:0] o_data;
  logic [AB-1:0] o_index;
  logic          o_last;
  logic          o_busy;
  logic          o_done;

  stacktr_reader #(.abits(AB)) dut (
    .i_clk   (i_clk),
    .i_nrst  (i_nrst),
    .i_start (i_start),
    .i_abort (i_abort),
    .i_depth (i_depth),
    .i_wptr  (i_wptr),
    .o_raddr (o_raddr),
    .i_rdata (i_rdata),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_index (o_index),
    .o_last  (o_last),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  always #5 i_clk = ~i_clk;

  // Buffer model: registered read, RAM[k] = k + 0x100.
  logic [DW-1:0] ram [32];
  initial begin
    for (int k = 0; k < 32; k++) ram[k] = DW'(k + 'h100);
  end
  always @(posedge i_clk) i_rdata <= ram[o_raddr];

  typedef struct {
    logic [DW-1:0] data;
    logic [AB-1:0] idx;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int done_seen = 0;
  int done_exp = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Model of the start address of a walk.
  function automatic int start_of(input int cnt, input int wptr);
`ifdef STACKTR_READER_WRAP_EN
    return (wptr - 1) & 31;
`else
    return (cnt - 1) & 31;
`endif
  endfunction

  // Push the first n beats of a walk of cnt entries starting at address st.
  task automatic push_walk(input int cnt, input int st, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = ram[(st - i) & 31];
      b.idx  = AB'(i);
      b.last = (i == cnt - 1);
      exp_q.push_back(b);
    end
  endtask

  // Monitor: pops on each accepted beat, then checks done/busy timing after the last one.
  initial begin
    beat_t b;
    bit pend_done = 0;
    bit pend_busy = 0;
    forever begin
      @(negedge i_clk);
      if (!i_nrst) begin
        pend_done = 0;
        pend_busy = 0;
      end else begin
        if (pend_busy) chk("busy_after_done", DW'(o_busy), DW'(0));
        pend_busy = 0;
        if (pend_done) begin
          chk("done_after_last", DW'(o_done), DW'(1));
          pend_busy = 1;
        end
        pend_done = 0;
        if (o_done) done_seen++;
        if (o_valid && i_ready && !i_abort) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL extra_beat: got index %0d data 0x%0h, required no beat", o_index, o_data);
          end else begin
            b = exp_q.pop_front();
            chk("beat_data", o_data, b.data);
            chk("beat_index", DW'(o_index), DW'(b.idx));
            chk("beat_last", DW'(o_last), DW'(b.last));
            if (b.last) pend_done = 1;
          end
        end
      end
    end
  end

  // Issue a dump and check the latency to the first beat (or to done for empty).
  task automatic start_dump(input int depth, input int wptr, input bit empty);
    int n;
    i_depth = (AB + 1)'(depth);
    i_wptr  = AB'(wptr);
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    n = 1;
    while (n < 10 && !(empty ? o_done : o_valid)) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk(empty ? "empty_done_latency" : "first_valid_latency", DW'(n), DW'(empty ? 1 : 3));
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (o_busy && n < budget) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk({name, "_idle"}, DW'(o_busy), DW'(0));
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    chk({name, "_queue_drained"}, DW'(exp_q.size()), DW'(0));
    chk({name, "_done_count"}, DW'(done_seen), DW'(done_exp));
  endtask

  task automatic wait_beat(input int idx, input string name);
    int n = 0;
    while (!(o_valid && o_index == AB'(idx)) && n < 60) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk({name, "_beat_reached"}, DW'(o_valid && o_index == AB'(idx)), DW'(1));
  endtask

  initial begin
    logic [DW-1:0] cap_data;
    logic [AB-1:0] cap_raddr;
    logic          cap_last;
    int            st;

    #12;
    chk("rst_valid", DW'(o_valid), DW'(0));
    chk("rst_busy", DW'(o_busy), DW'(0));
    chk("rst_done", DW'(o_done), DW'(0));
    chk("rst_last", DW'(o_last), DW'(0));
    chk("rst_data", o_data, DW'(0));
    chk("rst_index", DW'(o_index), DW'(0));
    chk("rst_raddr", DW'(o_raddr), DW'(0));
    @(posedge i_clk); #1;
    i_nrst = 1'b1;
    @(posedge i_clk); #1;

    // Three-entry dump at full rate: 0x102, 0x101, 0x100.
    i_ready = 1'b1;
    st = start_of(3, 3);
    push_walk(3, st, 3);
    done_exp++;
    start_dump(3, 3, 0);
    wait_idle(40, "lin3");

    // Consumer stall on beat 1 for 10 cycles.
    st = start_of(3, 3);
    push_walk(3, st, 3);
    done_exp++;
    start_dump(3, 3, 0);
    wait_beat(1, "stall");
    i_ready   = 1'b0;
    cap_data  = o_data;
    cap_raddr = o_raddr;
    cap_last  = o_last;
    chk("stall_data_value", cap_data, DW'('h101));
    for (int c = 0; c < 10; c++) begin
      @(posedge i_clk); #1;
      chk("stall_valid", DW'(o_valid), DW'(1));
      chk("stall_data", o_data, cap_data);
      chk("stall_index", DW'(o_index), DW'(1));
      chk("stall_last", DW'(o_last), DW'(cap_last));
      chk("stall_raddr", DW'(o_raddr), DW'(cap_raddr));
    end
    i_ready = 1'b1;
    wait_idle(40, "stall");

    // Abort on beat 2 together with ready, then restart from index 0.
    st = start_of(5, 5);
    push_walk(5, st, 2);
    start_dump(5, 5, 0);
    wait_beat(2, "abort");
    i_abort = 1'b1;
    @(posedge i_clk); #1;
    i_abort = 1'b0;
    chk("abort_busy", DW'(o_busy), DW'(0));
    chk("abort_valid", DW'(o_valid), DW'(0));
    wait_idle(20, "abort");
    st = start_of(2, 2);
    push_walk(2, st, 2);
    done_exp++;
    start_dump(2, 2, 0);
    chk("restart_index", DW'(o_index), DW'(0));
    wait_idle(40, "restart");

    // Empty dump: done one cycle after start, exactly one cycle wide.
    done_exp++;
    start_dump(0, 7, 1);
    chk("empty_no_valid", DW'(o_valid), DW'(0));
    @(posedge i_clk); #1;
    chk("empty_done_width", DW'(o_done), DW'(0));
    chk("empty_busy", DW'(o_busy), DW'(0));
    wait_idle(10, "empty");

    // Full buffer, wptr=2: wrap order 1,0,31..2; linear order 31..0.
    st = start_of(32, 2);
    push_walk(32, st, 32);
    done_exp++;
    start_dump(32, 2, 0);
    wait_idle(200, "full");

    // Oversized depth clamps to 32 entries.
    st = start_of(32, 2);
    push_walk(32, st, 32);
    done_exp++;
    start_dump(40, 2, 0);
    wait_idle(200, "sat");

    // Reset asserted while a beat is held.
    i_ready = 1'b0;
    start_dump(3, 3, 0);
    i_nrst = 1'b0;
    #1;
    chk("midrst_valid", DW'(o_valid), DW'(0));
    chk("midrst_busy", DW'(o_busy), DW'(0));
    chk("midrst_data", o_data, DW'(0));
    chk("midrst_raddr", DW'(o_raddr), DW'(0));
    chk("midrst_index", DW'(o_index), DW'(0));
    @(posedge i_clk); #1;
    i_nrst  = 1'b1;
    i_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge i_clk); #1;
      chk("postrst_busy", DW'(o_busy), DW'(0));
    end
    chk("postrst_done_count", DW'(done_seen), DW'(done_exp));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
